step_ctrl: RTL and testbench
============================

STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 SHALL provide parameter DB_CYCLES, default 500000, stable-input clkin cycles needed to accept a step_btn level change (10 ms at 50 MHz).
REQ-002 SHALL provide parameter CNT_W, default 16, width of step_cnt.
REQ-003 SHALL have port clkin  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port tick  input  1  divided slow clock from the clock divider, sampled as data, treated as asynchronous.
REQ-006 SHALL have port run_sw  input  1  raw slide switch; 1 = free-run, 0 = single-step.
REQ-007 SHALL have port step_btn  input  1  raw pushbutton, active-high, may bounce.
REQ-008 SHALL have port halt  input  1  CPU halt request, synchronous to clkin, level.
REQ-009 SHALL have port cpu_en  output  1  one-clkin-cycle CPU advance strobe.
REQ-010 SHALL have port state  output  2  FSM state: IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-011 SHALL have port step_cnt  output  CNT_W  number of cpu_en pulses issued.

Function
REQ-012 SHALL pass tick, run_sw and step_btn each through a 2-flop synchronizer before use.
REQ-013 SHALL form tick_rise as synced tick = 1 with previous synced value = 0; cpu_en (registered) goes high on the 3rd clkin edge after tick first samples high.
REQ-014 SHALL form press as the rising edge of the filtered step_btn level (filter per REQ-024).
REQ-015 SHALL evaluate transitions with priority halt > run_sw > press.
REQ-016 IDLE: cpu_en=0; halt -> HALTED; else run_sw=1 -> RUN; else press -> STEP.
REQ-017 RUN: cpu_en=tick_rise; halt -> HALTED (no pulse that cycle); run_sw=0 -> IDLE (no pulse that cycle).
REQ-018 STEP: on the first tick_rise issue exactly one cpu_en and return to IDLE; further presses ignored; halt -> HALTED with no pulse; run_sw=1 -> RUN.
REQ-019 HALTED: cpu_en=0, tick/press ignored; leaves to IDLE only when halt=0 and synced run_sw=0.
REQ-020 SHALL increment step_cnt on each cycle cpu_en=1, wrapping all-ones -> 0.
REQ-021 cpu_en SHALL never be high two consecutive cycles.

Reset
REQ-022 clr=1 SHALL immediately force state=IDLE, cpu_en=0, step_cnt=0, all synchronizer, edge and filter registers and the debounce counter to 0.
REQ-023 A tick already high at reset release SHALL produce one tick_rise (edge register resets to 0); clr mid-STEP SHALL discard the pending step.

Configuration
REQ-024 Macro STEP_CTRL_DEBOUNCE_EN defined: filtered level changes only after synced step_btn differs from it for DB_CYCLES consecutive cycles (counter clears on any mismatch break); undefined: filtered level = synced step_btn, DB_CYCLES unused, no counter logic.

Structure
REQ-025 SHALL place state encoding constants and the DB_CYCLES default in package step_ctrl_pkg.
REQ-026 SHALL implement the filter as sub-module btn_debounce (clkin, clr, din, dout), instantiated only with STEP_CTRL_DEBOUNCE_EN.

Verification (bench uses DB_CYCLES=4, tick period 20 clkin)
REQ-027 run_sw=1, 3 tick rises -> 3 cpu_en pulses, each 3 edges after tick rise, step_cnt 0->3, state=01.
REQ-028 run_sw=0, step_btn held 8 cycles -> state 10, one cpu_en at next tick rise, then state 00, step_cnt=1.
REQ-029 step_btn toggling every 2 cycles for 20 cycles, macro defined -> no press, state stays 00; macro undefined -> STEP entered.
REQ-030 halt=1 in RUN -> state 11, zero cpu_en over 5 tick rises; halt=0, run_sw=0 -> state 00.
REQ-031 CNT_W=4, run 17 tick rises -> step_cnt wraps 15->0, ends at 1.
REQ-032 clr pulsed mid-cycle while cpu_en=1 -> cpu_en, step_cnt, state 0 before next clkin edge.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// step_ctrl shared types and defaults.
// State encoding and debounce default length.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  // 10 ms of stable input at 50 MHz
  localparam int DB_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/step_ctrl_debounce.sv
// btn_debounce: level filter for a synced button.
// Output follows input after DB_CYCLES stable cycles.
module btn_debounce
  import step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clkin,
  input  logic clr,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // count consecutive mismatches; any agreement restarts
  always_ff @(posedge clkin or posedge clr) begin
    if (clr) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din != dout) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        dout <= din;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: run / single-step CPU clock enable.
// STEP_CTRL_DEBOUNCE_EN adds the step_btn filter.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clkin,
  input  logic             clr,
  input  logic             tick,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_cnt
);

  logic   t_s1, t_s2, t_q;
  logic   r_s1, run_s;
  logic   b_s1, b_s;
  logic   filt, filt_q;
  logic   tick_rise, press;
  logic   en_nxt;
  state_t st, st_nxt;

  // synchronizers plus edge-history flops
  always_ff @(posedge clkin or posedge clr) begin
    if (clr) begin
      t_s1   <= 1'b0;
      t_s2   <= 1'b0;
      t_q    <= 1'b0;
      r_s1   <= 1'b0;
      run_s  <= 1'b0;
      b_s1   <= 1'b0;
      b_s    <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      t_s1   <= tick;
      t_s2   <= t_s1;
      t_q    <= t_s2;
      r_s1   <= run_sw;
      run_s  <= r_s1;
      b_s1   <= step_btn;
      b_s    <= b_s1;
      filt_q <= filt;
    end
  end

`ifdef STEP_CTRL_DEBOUNCE_EN
  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db (
    .clkin(clkin),
    .clr  (clr),
    .din  (b_s),
    .dout (filt)
  );
`else
  logic unused_db;
  assign unused_db = (DB_CYCLES > 0);
  assign filt      = b_s;
`endif

  assign tick_rise = t_s2 & ~t_q;
  assign press     = filt & ~filt_q;

  // mode register, pulse register and pulse count
  always_ff @(posedge clkin or posedge clr) begin
    if (clr) begin
      st       <= IDLE;
      cpu_en   <= 1'b0;
      step_cnt <= '0;
    end else begin
      st       <= st_nxt;
      cpu_en   <= en_nxt;
      step_cnt <= step_cnt + CNT_W'(cpu_en);
    end
  end

  // next mode and pulse; halt beats run_sw beats press
  always_comb begin
    st_nxt = st;
    en_nxt = 1'b0;
    unique case (st)
      IDLE: begin
        if (halt)       st_nxt = HALTED;
        else if (run_s) st_nxt = RUN;
        else if (press) st_nxt = STEP;
      end
      RUN: begin
        if (halt)        st_nxt = HALTED;
        else if (!run_s) st_nxt = IDLE;
        else             en_nxt = tick_rise;
      end
      STEP: begin
        if (halt)       st_nxt = HALTED;
        else if (run_s) st_nxt = RUN;
        else if (tick_rise) begin
          en_nxt = 1'b1;
          st_nxt = IDLE;
        end
      end
      HALTED: begin
        if (!halt && !run_s) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign state = st;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: directed bench with a cycle model.
// Honours STEP_CTRL_DEBOUNCE_EN for the bounce case.
module tb_step_ctrl;

  localparam int DB = 4;
  localparam int CW = 4;

  logic          clkin;
  logic          clr;
  logic          tick;
  logic          run_sw;
  logic          step_btn;
  logic          halt;
  logic          cpu_en;
  logic [1:0]    state;
  logic [CW-1:0] step_cnt;

  int ncmp = 0;
  int nerr = 0;
  bit chk_on = 0;

  step_ctrl #(
    .DB_CYCLES(DB),
    .CNT_W    (CW)
  ) dut (
    .clkin   (clkin),
    .clr     (clr),
    .tick    (tick),
    .run_sw  (run_sw),
    .step_btn(step_btn),
    .halt    (halt),
    .cpu_en  (cpu_en),
    .state   (state),
    .step_cnt(step_cnt)
  );

  initial begin
    clkin = 0;
    forever #5 clkin = ~clkin;
  end

  // tick: 10 high, 10 low, changes on falling clkin
  initial begin
    int tc;
    tc   = 0;
    tick = 0;
    forever begin
      @(negedge clkin);
      tc   = (tc + 1) % 20;
      tick = (tc < 10);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // behavioural model: raw inputs seen two edges late
  logic [3:0] th, rh, bh;
  int m_st, m_en, m_cnt, m_fl, m_flp, m_dbc;

  always @(posedge clkin or posedge clr) begin
    if (clr) begin
      th    <= '0;
      rh    <= '0;
      bh    <= '0;
      m_st  <= 0;
      m_en  <= 0;
      m_cnt <= 0;
      m_fl  <= 0;
      m_flp <= 0;
      m_dbc <= 0;
    end else begin : mdl
      int rise, rs, pr, nst, nen, nfl, ndbc;
      rise = (th[1] && !th[2]) ? 1 : 0;
      rs   = bh[1] ? 0 : 0;
      rs   = rh[1] ? 1 : 0;
`ifdef STEP_CTRL_DEBOUNCE_EN
      pr = (m_fl == 1 && m_flp == 0) ? 1 : 0;
`else
      pr = (bh[1] && !bh[2]) ? 1 : 0;
`endif
      nst = m_st;
      nen = 0;
      case (m_st)
        0: if (halt) nst = 3;
           else if (rs == 1) nst = 1;
           else if (pr == 1) nst = 2;
        1: if (halt) nst = 3;
           else if (rs == 0) nst = 0;
           else nen = rise;
        2: if (halt) nst = 3;
           else if (rs == 1) nst = 1;
           else if (rise == 1) begin
             nen = 1;
             nst = 0;
           end
        default: if (!halt && rs == 0) nst = 0;
      endcase
      nfl  = m_fl;
      ndbc = 0;
      if (int'(bh[1]) != m_fl) begin
        if (m_dbc == DB - 1) nfl = int'(bh[1]);
        else ndbc = m_dbc + 1;
      end
      m_cnt <= (m_cnt + m_en) % 16;
      m_st  <= nst;
      m_en  <= nen;
      m_flp <= m_fl;
      m_fl  <= nfl;
      m_dbc <= ndbc;
      th    <= {th[2:0], tick};
      rh    <= {rh[2:0], run_sw};
      bh    <= {bh[2:0], step_btn};
    end
  end

  // every-cycle compare against the model
  always @(negedge clkin) begin
    if (chk_on && !clr) begin
      chk("m_cpu_en", int'(cpu_en), m_en);
      chk("m_state", int'(state), m_st);
      chk("m_step_cnt", int'(step_cnt), m_cnt);
    end
  end

  task automatic wait_rise();
    logic prev;
    bit   got;
    got = 0;
    @(posedge clkin);
    prev = tick;
    for (int i = 0; i < 50; i++) begin
      @(posedge clkin);
      if (tick && !prev) begin
        got = 1;
        break;
      end
      prev = tick;
    end
    if (!got) chk("tick_rise_wait", 0, 1);
  endtask

  // pulse appears after the 3rd edge that sees tick
  task automatic lat_pulse();
    wait_rise();
    #1 chk("lat_e1", int'(cpu_en), 0);
    @(posedge clkin);
    #1 chk("lat_e2", int'(cpu_en), 0);
    @(posedge clkin);
    #1 chk("lat_e3", int'(cpu_en), 1);
  endtask

  task automatic pulse_clr();
    @(negedge clkin) clr = 1;
    @(negedge clkin) clr = 0;
  endtask

  initial begin
    int  npl;
    bit  saw, got;
    int  exp_saw;
    clr      = 1;
    run_sw   = 0;
    step_btn = 0;
    halt     = 0;
    repeat (3) @(negedge clkin);
    chk("rst_state", int'(state), 0);
    chk("rst_cpu_en", int'(cpu_en), 0);
    chk("rst_cnt", int'(step_cnt), 0);
    clr    = 0;
    chk_on = 1;

    // free run: three pulses
    wait_rise();
    @(negedge clkin) run_sw = 1;
    repeat (3) lat_pulse();
    @(posedge clkin);
    #1 chk("run_cnt", int'(step_cnt), 3);
    chk("run_state", int'(state), 1);
    @(negedge clkin) run_sw = 0;
    repeat (4) @(negedge clkin);
    chk("run_exit", int'(state), 0);

    // single step from a held button
    pulse_clr();
    wait_rise();
    @(negedge clkin) step_btn = 1;
    repeat (8) @(negedge clkin);
    step_btn = 0;
    repeat (4) @(negedge clkin);
    chk("step_state", int'(state), 2);
    wait_rise();
    repeat (3) @(posedge clkin);
    #1 chk("step_cnt1", int'(step_cnt), 1);
    chk("step_idle", int'(state), 0);

    // bouncing button
    pulse_clr();
    wait_rise();
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clkin) step_btn = ~step_btn;
      if (state == 2'b10) saw = 1;
      @(negedge clkin);
      if (state == 2'b10) saw = 1;
    end
    repeat (8) begin
      @(negedge clkin);
      if (state == 2'b10) saw = 1;
    end
`ifdef STEP_CTRL_DEBOUNCE_EN
    exp_saw = 0;
`else
    exp_saw = 1;
`endif
    chk("bounce_step", int'(saw), exp_saw);

    // halt while running
    pulse_clr();
    wait_rise();
    @(negedge clkin) run_sw = 1;
    repeat (4) @(negedge clkin);
    halt = 1;
    repeat (2) @(negedge clkin);
    chk("halt_state", int'(state), 3);
    npl = 0;
    repeat (110) begin
      @(posedge clkin);
      #1 npl += int'(cpu_en);
    end
    chk("halt_pulses", npl, 0);
    @(negedge clkin);
    halt   = 0;
    run_sw = 0;
    repeat (2) @(negedge clkin);
    chk("halt_hold", int'(state), 3);
    repeat (2) @(negedge clkin);
    chk("halt_exit", int'(state), 0);

    // counter wrap with a 4-bit count
    pulse_clr();
    wait_rise();
    @(negedge clkin) run_sw = 1;
    for (int i = 0; i < 17; i++) begin
      lat_pulse();
      if (i == 15) begin
        @(posedge clkin);
        #1 chk("wrap_zero", int'(step_cnt), 0);
      end
    end
    @(posedge clkin);
    #1 chk("wrap_end", int'(step_cnt), 1);

    // async clear in the middle of a pulse
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clkin);
      #1;
      if (cpu_en) begin
        got = 1;
        break;
      end
    end
    chk("clr_found_pulse", int'(got), 1);
    #2 clr = 1;
    #1;
    chk("clr_cpu_en", int'(cpu_en), 0);
    chk("clr_cnt", int'(step_cnt), 0);
    chk("clr_state", int'(state), 0);
    @(negedge clkin) clr = 0;
    run_sw = 0;
    repeat (6) @(negedge clkin);

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
